// File: rtl/game_sequencer.sv
// Game-flow controller for Frogger: sequences idle/play/dying/level-done/game-over/win,
// tracks lives, level and the per-attempt frame timer, and drives traffic/frog/screen controls.
module game_sequencer #(
    parameter int LIVES       = 3,
    parameter int NUM_LEVELS  = 4,
    parameter int TIME_FRAMES = 1800,
    parameter int HOLD_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        update,
    input  logic        start,
    input  logic        collide,
    input  logic        reach_end,
    output logic [2:0]  state,
    output logic [1:0]  level,
    output logic [1:0]  lives,
    output logic [10:0] timer,
    output logic        traffic_en,
    output logic        frog_reset,
    output logic        flash,
    output logic        show_win,
    output logic        show_game_over
);

    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
    localparam logic [1:0]  LAST_LEVEL = 2'(NUM_LEVELS - 1);
    localparam logic [10:0] TIMER_INIT = 11'(TIME_FRAMES);
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PLAY       = 3'd1,
        S_DYING      = 3'd2,
        S_LEVEL_DONE = 3'd3,
        S_GAME_OVER  = 3'd4,
        S_WIN        = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  level_q, level_d;
    logic [1:0]  lives_q, lives_d;
    logic [10:0] timer_q, timer_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        start_q;
    logic        armed_q;
    logic        traffic_en_q, traffic_en_d;
    logic        frog_reset_q, frog_reset_d;
    logic        flash_q, flash_d;
    logic        show_win_q, show_win_d;
    logic        show_game_over_q, show_game_over_d;

    logic start_edge;
    logic in_hold;
    logic hold_expire;
    logic next_in_hold;

    // armed_q blocks a start button that was already held when reset released
    assign start_edge  = start & ~start_q & armed_q;
    assign in_hold     = (state_q == S_DYING) || (state_q == S_LEVEL_DONE);
    assign hold_expire = in_hold && update && (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        lives_d    = lives_q;
        timer_d    = timer_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (collide) begin
                    state_d = S_DYING;
                end else if (reach_end) begin
                    state_d = S_LEVEL_DONE;
                end else if (update) begin
                    if (timer_q == 11'd1) begin
                        state_d = S_DYING;
                        timer_d = 11'd0;
                    end else if (timer_q != 11'd0) begin
                        timer_d = timer_q - 11'd1;
                    end
                end
            end
            S_DYING: begin
                if (hold_expire) begin
                    if (lives_q <= 2'd1) begin
                        state_d = S_GAME_OVER;
                        lives_d = 2'd0;
                    end else begin
                        state_d = S_PLAY;
                        lives_d = lives_q - 2'd1;
                        timer_d = TIMER_INIT;
                    end
                end else if (update) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            S_LEVEL_DONE: begin
                if (hold_expire) begin
                    if (level_q >= LAST_LEVEL) begin
                        state_d = S_WIN;
                    end else begin
                        state_d = S_PLAY;
                        level_d = level_q + 2'd1;
                        timer_d = TIMER_INIT;
                    end
                end else if (update) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            S_GAME_OVER, S_WIN: begin
                if (start_edge) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        next_in_hold = (state_d == S_DYING) || (state_d == S_LEVEL_DONE);
        if (next_in_hold && (state_d != state_q)) begin
            hold_cnt_d = 8'd0;
        end

        // Game parameters are reloaded on the way into IDLE so they read correctly immediately
        if (state_d == S_IDLE) begin
            lives_d = LIVES_INIT;
            level_d = 2'd0;
            timer_d = TIMER_INIT;
        end

        traffic_en_d     = (state_d == S_PLAY);
        frog_reset_d     = (state_d == S_PLAY) && (state_q != S_PLAY);
        flash_d          = next_in_hold ? hold_cnt_d[3] : 1'b0;
        show_win_d       = (state_d == S_WIN);
        show_game_over_d = (state_d == S_GAME_OVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            level_q          <= 2'd0;
            lives_q          <= LIVES_INIT;
            timer_q          <= TIMER_INIT;
            hold_cnt_q       <= 8'd0;
            start_q          <= 1'b0;
            armed_q          <= 1'b0;
            traffic_en_q     <= 1'b0;
            frog_reset_q     <= 1'b0;
            flash_q          <= 1'b0;
            show_win_q       <= 1'b0;
            show_game_over_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            level_q          <= level_d;
            lives_q          <= lives_d;
            timer_q          <= timer_d;
            hold_cnt_q       <= hold_cnt_d;
            start_q          <= start;
            armed_q          <= armed_q | ~start;
            traffic_en_q     <= traffic_en_d;
            frog_reset_q     <= frog_reset_d;
            flash_q          <= flash_d;
            show_win_q       <= show_win_d;
            show_game_over_q <= show_game_over_d;
        end
    end

    assign state          = state_q;
    assign level          = level_q;
    assign lives          = lives_q;
    assign timer          = timer_q;
    assign traffic_en     = traffic_en_q;
    assign frog_reset     = frog_reset_q;
    assign flash          = flash_q;
    assign show_win       = show_win_q;
    assign show_game_over = show_game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: a vector table on a short-timer instance plus hand sequences
// on a default-parameter instance for deaths, levels, win/game-over and mid-run reset.
module tb_game_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // instance A: default parameters
    logic a_update = 0, a_start = 0, a_collide = 0, a_reach = 0;
    logic [2:0] a_state;
    logic [1:0] a_level, a_lives;
    logic [10:0] a_timer;
    logic a_traffic, a_frog, a_flash, a_win, a_go;

    // instance B: TIME_FRAMES=4, HOLD_FRAMES=3
    logic b_update = 0, b_start = 0, b_collide = 0, b_reach = 0;
    logic [2:0] b_state;
    logic [1:0] b_level, b_lives;
    logic [10:0] b_timer;
    logic b_traffic, b_frog, b_flash, b_win, b_go;

    game_sequencer dut_a (
        .clk(clk), .rst(rst), .update(a_update), .start(a_start),
        .collide(a_collide), .reach_end(a_reach),
        .state(a_state), .level(a_level), .lives(a_lives), .timer(a_timer),
        .traffic_en(a_traffic), .frog_reset(a_frog), .flash(a_flash),
        .show_win(a_win), .show_game_over(a_go)
    );

    game_sequencer #(.TIME_FRAMES(4), .HOLD_FRAMES(3)) dut_b (
        .clk(clk), .rst(rst), .update(b_update), .start(b_start),
        .collide(b_collide), .reach_end(b_reach),
        .state(b_state), .level(b_level), .lives(b_lives), .timer(b_timer),
        .traffic_en(b_traffic), .frog_reset(b_frog), .flash(b_flash),
        .show_win(b_win), .show_game_over(b_go)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        st, up, co, re;
        logic [2:0]  e_state;
        logic [10:0] e_timer;
        logic [1:0]  e_lives, e_level;
        logic        e_frog;
    } vec_t;

    vec_t vecs [28];

    function automatic vec_t mk(input logic st, up, co, re, input logic [2:0] s,
                                input logic [10:0] t, input logic [1:0] l, lv, input logic f);
        vec_t v;
        v.st = st; v.up = up; v.co = co; v.re = re;
        v.e_state = s; v.e_timer = t; v.e_lives = l; v.e_level = lv; v.e_frog = f;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 59 update strobes inside a hold state; the caller supplies the expiring one
    task automatic hold_wait(input logic [2:0] exp_state);
        a_update = 1;
        for (int i = 1; i <= 59; i++) begin
            tick();
            if (i == 1)  check("hold_flash_lo", a_flash, 0);
            if (i == 8)  check("hold_flash_hi", a_flash, 1);
            if (i == 59) check("hold_state", a_state, exp_state);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(0,0,0,0, 0,4,3,0,0);
        vecs[1]  = mk(1,0,0,0, 1,4,3,0,1);
        vecs[2]  = mk(0,1,0,0, 1,3,3,0,0);
        vecs[3]  = mk(0,1,0,0, 1,2,3,0,0);
        vecs[4]  = mk(0,1,0,0, 1,1,3,0,0);
        vecs[5]  = mk(0,1,0,0, 2,0,3,0,0);
        vecs[6]  = mk(0,1,0,0, 2,0,3,0,0);
        vecs[7]  = mk(0,1,0,0, 2,0,3,0,0);
        vecs[8]  = mk(0,1,0,0, 1,4,2,0,1);
        vecs[9]  = mk(0,1,0,0, 1,3,2,0,0);
        vecs[10] = mk(0,1,0,0, 1,2,2,0,0);
        vecs[11] = mk(0,1,0,0, 1,1,2,0,0);
        vecs[12] = mk(0,1,0,1, 3,1,2,0,0);
        vecs[13] = mk(0,1,0,0, 3,1,2,0,0);
        vecs[14] = mk(0,1,0,0, 3,1,2,0,0);
        vecs[15] = mk(0,1,0,0, 1,4,2,1,1);
        vecs[16] = mk(0,0,1,1, 2,4,2,1,0);
        vecs[17] = mk(0,0,0,0, 2,4,2,1,0);
        vecs[18] = mk(0,1,0,0, 2,4,2,1,0);
        vecs[19] = mk(0,1,0,0, 2,4,2,1,0);
        vecs[20] = mk(0,1,0,0, 1,4,1,1,1);
        vecs[21] = mk(1,1,0,0, 1,3,1,1,0);
        vecs[22] = mk(0,0,1,0, 2,3,1,1,0);
        vecs[23] = mk(0,1,0,0, 2,3,1,1,0);
        vecs[24] = mk(0,1,0,0, 2,3,1,1,0);
        vecs[25] = mk(0,1,0,0, 4,3,0,1,0);
        vecs[26] = mk(1,0,0,0, 0,4,3,0,0);
        vecs[27] = mk(0,0,0,0, 0,4,3,0,0);

        // reset values while rst is held low
        tick(); tick();
        check("rst_state", a_state, 0);
        check("rst_level", a_level, 0);
        check("rst_lives", a_lives, 3);
        check("rst_timer", a_timer, 1800);
        check("rst_traffic", a_traffic, 0);
        check("rst_frog", a_frog, 0);
        check("rst_flash", a_flash, 0);
        check("rst_win", a_win, 0);
        check("rst_go", a_go, 0);
        rst = 1;

        // table-driven run on the short-timer instance
        for (int i = 0; i < 28; i++) begin
            b_start = vecs[i].st; b_update = vecs[i].up;
            b_collide = vecs[i].co; b_reach = vecs[i].re;
            tick();
            $display("vec %0d: state=%0d timer=%0d lives=%0d level=%0d frog=%0d",
                     i, b_state, b_timer, b_lives, b_level, b_frog);
            check("vec_state", b_state, vecs[i].e_state);
            check("vec_timer", b_timer, vecs[i].e_timer);
            check("vec_lives", b_lives, vecs[i].e_lives);
            check("vec_level", b_level, vecs[i].e_level);
            check("vec_frog", b_frog, vecs[i].e_frog);
            check("vec_traffic", b_traffic, (vecs[i].e_state == 3'd1));
        end
        b_start = 0; b_update = 0; b_collide = 0; b_reach = 0;

        // start a game
        a_start = 1; tick();
        $display("start: state=%0d frog=%0d", a_state, a_frog);
        check("start_state", a_state, 1);
        check("start_frog", a_frog, 1);
        check("start_lives", a_lives, 3);
        check("start_level", a_level, 0);
        check("start_timer", a_timer, 1800);
        check("start_traffic", a_traffic, 1);
        a_start = 0; tick();
        check("frog_one_cycle", a_frog, 0);
        check("play_hold", a_state, 1);

        // two deaths back to PLAY
        for (int d = 0; d < 2; d++) begin
            a_collide = 1; tick(); a_collide = 0;
            check("die_state", a_state, 2);
            check("die_traffic", a_traffic, 0);
            hold_wait(3'd2);
            tick(); a_update = 0;
            $display("death %0d: state=%0d lives=%0d", d, a_state, a_lives);
            check("respawn_state", a_state, 1);
            check("respawn_lives", a_lives, 2 - d);
            check("respawn_timer", a_timer, 1800);
            check("respawn_frog", a_frog, 1);
        end

        // third death with a start edge on the expiry cycle
        a_collide = 1; tick(); a_collide = 0;
        hold_wait(3'd2);
        a_start = 1; tick(); a_update = 0;
        $display("death 2: state=%0d lives=%0d go=%0d", a_state, a_lives, a_go);
        check("go_state", a_state, 4);
        check("go_lives", a_lives, 0);
        check("go_show", a_go, 1);
        check("go_traffic", a_traffic, 0);
        tick();
        check("go_start_held", a_state, 4);
        a_start = 0; tick(); a_start = 1; tick();
        check("go_to_idle", a_state, 0);
        check("idle_lives", a_lives, 3);
        check("idle_go_clear", a_go, 0);
        a_start = 0; tick();

        // new game: collide and reach_end together
        a_start = 1; tick(); a_start = 0;
        check("game2_state", a_state, 1);
        a_collide = 1; a_reach = 1; tick(); a_collide = 0; a_reach = 0;
        check("both_dying", a_state, 2);
        hold_wait(3'd2);
        tick(); a_update = 0;
        check("both_respawn_lives", a_lives, 2);

        // levels 0..3 then WIN
        for (int lv = 0; lv < 4; lv++) begin
            a_reach = 1; tick(); a_reach = 0;
            check("ld_state", a_state, 3);
            check("ld_level", a_level, lv);
            hold_wait(3'd3);
            tick(); a_update = 0;
            $display("level %0d done: state=%0d level=%0d", lv, a_state, a_level);
            if (lv < 3) begin
                check("next_state", a_state, 1);
                check("next_level", a_level, lv + 1);
                check("next_frog", a_frog, 1);
                check("next_timer", a_timer, 1800);
            end else begin
                check("win_state", a_state, 5);
                check("win_show", a_win, 1);
                check("win_level", a_level, 3);
                check("win_traffic", a_traffic, 0);
            end
        end
        a_start = 1; tick(); a_start = 0;
        check("win_to_idle", a_state, 0);
        check("win_clear", a_win, 0);
        tick();

        // reset mid-DYING with start held
        a_start = 1; tick(); a_start = 0; tick();
        a_collide = 1; tick(); a_collide = 0;
        a_update = 1;
        repeat (10) tick();
        check("mid_flash", a_flash, 1);
        a_start = 1;
        #2 rst = 0;
        #1;
        $display("async reset: state=%0d lives=%0d timer=%0d", a_state, a_lives, a_timer);
        check("ar_state", a_state, 0);
        check("ar_lives", a_lives, 3);
        check("ar_timer", a_timer, 1800);
        check("ar_flash", a_flash, 0);
        check("ar_traffic", a_traffic, 0);
        tick();
        rst = 1; a_update = 0;
        repeat (3) tick();
        check("held_start_idle", a_state, 0);
        a_start = 0; tick(); a_start = 1; tick();
        check("restart_state", a_state, 1);
        check("restart_frog", a_frog, 1);
        a_start = 0; tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
